// File: rtl/rv_mem_pkg.sv
// Shared encodings and helpers for the data-memory access sequencer.
// Request sizes, FSM state encoding, the misalignment rule and
// lane byte-enable decode live here so the top and the merge unit agree.
package rv_mem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD    = 3'd1;
    localparam logic [2:0] ST_WR    = 3'd2;
    localparam logic [2:0] ST_LDRSP = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        RD    = ST_RD,
        WR    = ST_WR,
        LDRSP = ST_LDRSP,
        ERR   = ST_ERR
    } state_t;

    // Halfwords need an even address, words (and size 11) need a 4-byte boundary.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return addr_lo[0];
            default: return addr_lo != 2'b00;
        endcase
    endfunction

    // Byte lanes touched by an aligned access of the given size.
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_B:  return 4'b0001 << addr_lo;
            SIZE_H:  return addr_lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge for sub-word stores.
// Replicates the LSB-justified store data across lanes, derives the byte
// enables from size/offset, and splices the enabled lanes into the old word.
module store_lane_merge
    import rv_mem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    output logic [31:0] merged,
    output logic [31:0] lane_data,
    output logic [3:0]  be
);

    // Replicate the lane, then take enabled bytes from it and the rest from the old word.
    always_comb begin
        be        = lane_be(size, addr_lo);
        lane_data = new_data;
        case (size)
            SIZE_B:  lane_data = {4{new_data[7:0]}};
            SIZE_H:  lane_data = {2{new_data[15:0]}};
            default: lane_data = new_data;
        endcase
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = lane_data[8*i +: 8];
        end
    end

endmodule

// File: rtl/store_rmw_ctrl.sv
// Data-memory access sequencer between the MEM-stage request and a
// word-wide synchronous RAM. Word stores write directly, sub-word stores
// read-merge-write, loads return the raw word, misaligned requests get an
// error response without touching the RAM.
// Build option: STORE_RMW_BYTE_EN_EN -- the RAM honours byte enables, so
// sub-word stores become single direct writes with replicated lane data.
//
// Handshake: a request is taken on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE, so there is never a back-to-back accept and
// req_valid activity while busy is ignored. resp_valid is a one-cycle pulse.
module store_rmw_ctrl
    import rv_mem_pkg::*;
#(
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata,
    output logic              busy,
    output logic [2:0]        dbg_state
);

    state_t      state;
    logic        we_q;
    logic [1:0]  size_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] wdata_q;

    logic [31:0] merged;
    logic [31:0] lane_data;
    logic [3:0]  merge_be;
    logic        direct_store;

    // Upper address bits wrap by design.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:MEM_AW+2];

    assign dbg_state = state;

`ifdef STORE_RMW_BYTE_EN_EN
    assign direct_store = 1'b1;
    logic unused_merge;
    assign unused_merge = ^merged;
`else
    assign direct_store = req_size[1];
    logic unused_merge;
    assign unused_merge = ^{merge_be, lane_data};
`endif

    store_lane_merge u_merge (
        .old_word  (mem_rdata),
        .new_data  (wdata_q),
        .addr_lo   (addr_lo_q),
        .size      (size_q),
        .merged    (merged),
        .lane_data (lane_data),
        .be        (merge_be)
    );

    // Sequencer: one transition per cycle, control outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            we_q       <= 1'b0;
            size_q     <= SIZE_W;
            addr_lo_q  <= 2'b00;
            wdata_q    <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        size_q    <= req_size;
                        addr_lo_q <= req_addr[1:0];
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (misaligned(req_size, req_addr[1:0])) begin
                            state      <= ERR;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (req_we && direct_store) begin
                            state      <= WR;
                            mem_en     <= 1'b1;
                            mem_we     <= 1'b1;
                            mem_addr   <= req_addr[MEM_AW+1:2];
                            resp_valid <= 1'b1;
                        end else begin
                            state    <= RD;
                            mem_en   <= 1'b1;
                            mem_addr <= req_addr[MEM_AW+1:2];
                        end
                    end
                end
                RD: begin
                    if (we_q) begin
                        state      <= WR;
                        mem_en     <= 1'b1;
                        mem_we     <= 1'b1;
                        resp_valid <= 1'b1;
                    end else begin
                        state      <= LDRSP;
                        mem_addr   <= '0;
                        resp_valid <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    mem_addr  <= '0;
                end
            endcase
        end
    end

    // Data paths decoded from state: write data/enables in WR, load word in LDRSP, zero otherwise.
    always_comb begin
        mem_wdata  = '0;
        mem_be     = '0;
        resp_rdata = '0;
        if (state == WR) begin
`ifdef STORE_RMW_BYTE_EN_EN
            mem_wdata = lane_data;
            mem_be    = merge_be;
`else
            mem_wdata = merged;
            mem_be    = 4'b1111;
`endif
        end
        if (state == LDRSP) resp_rdata = mem_rdata;
    end

endmodule
